// File: rtl/ulpi_encoder.sv
// ulpi_encoder: transmit-side ULPI link encoder. Turns the PID byte of each
// upstream packet into a TX CMD, paces payload bytes on ulpi_nxt_i, ends the
// packet with STP and recovers from underrun or PHY bus turnaround.
`timescale 1ns/1ps

module ulpi_encoder (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_tvalid_i,
    output logic       tx_tready_o,
    input  logic       tx_tlast_i,
    input  logic [7:0] tx_tdata_i,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    output logic [7:0] ulpi_data_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       tx_error_o
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SEND  = 4'b0010,
        ST_STOP  = 4'b0100,
        ST_DRAIN = 4'b1000
    } state_t;

    localparam logic [3:0] TXCMD_TRANSMIT = 4'b0100;

    state_t     state_q, state_d;
    logic       dir_q;
    logic       last_q, last_d;
    logic       abort_q, abort_d;
    logic [7:0] data_d;
    logic       stp_d;
    logic       tready, done, error;

    // Next-state, next-bus-value and handshake decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        data_d  = ulpi_data_o;
        stp_d   = ulpi_stp_o;
        last_d  = last_q;
        abort_d = abort_q;
        tready  = 1'b0;
        done    = 1'b0;
        error   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                data_d = 8'h00;
                stp_d  = 1'b0;
                // dir_q keeps the turnaround cycle after the PHY releases the bus.
                if (tx_tvalid_i && !ulpi_dir_i && !dir_q) begin
                    tready  = 1'b1;
                    data_d  = {TXCMD_TRANSMIT, tx_tdata_i[3:0]};
                    last_d  = tx_tlast_i;
                    abort_d = 1'b0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (ulpi_dir_i) begin
                    // PHY took the bus: abandon the packet, drain what is left.
                    data_d  = 8'h00;
                    error   = 1'b1;
                    state_d = last_q ? ST_IDLE : ST_DRAIN;
                end else if (ulpi_nxt_i) begin
                    if (last_q) begin
                        data_d  = 8'h00;
                        stp_d   = 1'b1;
                        state_d = ST_STOP;
                    end else if (tx_tvalid_i) begin
                        tready = 1'b1;
                        data_d = tx_tdata_i;
                        last_d = tx_tlast_i;
                    end else begin
                        // Underrun: STP with all-ones data makes the PHY
                        // send a bit-stuff error so the host drops the packet.
                        data_d  = 8'hFF;
                        stp_d   = 1'b1;
                        error   = 1'b1;
                        abort_d = 1'b1;
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                data_d  = 8'h00;
                stp_d   = 1'b0;
                done    = !abort_q;
                abort_d = 1'b0;
                state_d = abort_q ? ST_DRAIN : ST_IDLE;
            end

            ST_DRAIN: begin
                tready = 1'b1;
                data_d = 8'h00;
                if (tx_tvalid_i && tx_tlast_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                data_d  = 8'h00;
                stp_d   = 1'b0;
            end
        endcase
    end

    // State and bus registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b1;
            last_q      <= 1'b0;
            abort_q     <= 1'b0;
            ulpi_data_o <= 8'h00;
            ulpi_stp_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= ulpi_dir_i;
            last_q      <= last_d;
            abort_q     <= abort_d;
            ulpi_data_o <= data_d;
            ulpi_stp_o  <= stp_d;
        end
    end

    // Combinational outputs are forced idle while reset is held.
    assign tx_tready_o = tready && !reset;
    assign tx_done_o   = done && !reset;
    assign tx_error_o  = error && !reset;
    assign busy_o      = (state_q != ST_IDLE) && !reset;

endmodule
